// File: rtl/avalon_onchip_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for the pipelined on-chip RAM.
// Carries the request/response signals plus the clock enable and init status.
interface avalon_onchip_ram_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  logic                init_done;

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken,
    output readdata, readdatavalid, waitrequest, init_done
  );

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken,
    input  readdata, readdatavalid, waitrequest, init_done
  );
endinterface

// File: rtl/avalon_onchip_ram_pipelined.sv
// Parametrised single-port Avalon-MM on-chip RAM with 1- or 2-cycle
// pipelined reads, byte-lane writes, clken stall and an optional
// clear-after-reset sequencer that zeroes every word before traffic.
module avalon_onchip_ram_pipelined #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                           clk,
  input logic                           reset_n,
  avalon_onchip_ram_pipelined_if.slave  bus
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam int              NB       = DATA_W / 8;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     clr_cnt;   // one spare bit so the sweep never wraps
  logic                init_done_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_q;      // RAM output register
  logic                rd_v;

  logic clr_we;
  logic wr_acc;
  logic rd_acc;

  // Write wins over read when both are requested in the same cycle.
  assign clr_we = (state == ST_INIT) & bus.clken;
  assign wr_acc = (state == ST_RUN) & bus.chipselect & bus.write & bus.clken;
  assign rd_acc = (state == ST_RUN) & bus.chipselect & bus.read & ~bus.write & bus.clken;

  assign bus.waitrequest = (state != ST_RUN) | ~bus.clken;
  assign bus.init_done   = init_done_q;

  // Clear sequencer: sweep every address once, then open the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state       <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_done_q <= (CLEAR_ON_RESET == 0);
      clr_cnt     <= '0;
    end else if (clr_we) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST_IDX) begin
        state       <= ST_RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  // Storage array: clear writes during INIT, byte-lane writes during RUN.
  // NOTE: the array has no reset branch; resetting a memory turns it into
  // flops. Contents are zeroed by the sequencer instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.byteenable[i]) mem[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  // First read stage: registered RAM output and its valid flag, frozen by clken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else if (bus.clken) begin
      rd_v <= rd_acc;
      if (rd_acc) rd_q <= mem[bus.address];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] out_q;
      logic              out_v;

      // Second read stage: extra output register for timing closure.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else if (bus.clken) begin
          out_q <= rd_q;
          out_v <= rd_v;
        end
      end

      assign bus.readdata      = out_q;
      assign bus.readdatavalid = out_v;
    end else begin : g_lat1
      assign bus.readdata      = rd_q;
      assign bus.readdatavalid = rd_v;
    end
  endgenerate

endmodule

// File: doc/avalon_onchip_ram_pipelined.md
Name: avalon_onchip_ram_pipelined

Overview:
- Parametrised single-port Avalon-MM on-chip RAM slave for the NIOS system; successor to the fixed 32-bit x 32K, zero-latency-flagged RAM.
- Generalised data width and depth; selectable 1- or 2-cycle pipelined read with readdatavalid.
- Waitrequest-based stall via clken; optional hardware clear-on-reset sequencer with init_done status.
- Sits on the system interconnect as program/data memory, or as a scratch buffer for peripherals.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 15, word address width; DEPTH = 2**ADDR_W words
READ_LATENCY, 1, accepted read to readdatavalid in cycles; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  write byte-lane enables
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
clken  in  1  clock enable; low = stall
readdata  out  DATA_W  read data, qualified by readdatavalid
readdatavalid  out  1  one-cycle pulse per accepted read
waitrequest  out  1  high = request not accepted this cycle
init_done  out  1  high once memory is usable

Behaviour:
- Reset (reset_n low, asynchronous):
  - readdata = 0, readdatavalid = 0, pipeline valid bits = 0, clear counter = 0.
  - State = INIT if CLEAR_ON_RESET = 1, otherwise RUN.
  - waitrequest = 1 and init_done = 0 in INIT; waitrequest = 0 and init_done = 1 in RUN.
- FSM INIT:
  - Writes all-zero data, all lanes, one word per cycle at the counter address. Counter runs 0 to DEPTH-1; bus requests are ignored.
  - The cycle after the write to DEPTH-1, state goes to RUN and init_done goes to 1.
  - Exactly DEPTH write cycles after reset release; waitrequest falls at the same edge init_done rises.
  - The counter is ADDR_W+1 bits wide to detect completion without wrap.
- FSM RUN:
  - waitrequest = ~clken, combinational.
  - Write accepted when chipselect & write & clken. Only lanes with byteenable[i] = 1 update bits [8i+7:8i].
  - Read accepted when chipselect & read & ~write & clken. read and write both high is a write only: no readdatavalid is generated.
  - READ_LATENCY 1: the RAM output register drives readdata; readdatavalid pulses 1 cycle after acceptance.
  - READ_LATENCY 2: an extra output register; readdatavalid pulses 2 cycles after acceptance.
  - Back-to-back reads: one accepted per cycle, one valid per cycle, in order.
  - Read-after-write: a read accepted in the cycle after a write to the same address returns the new data, including byte merge. Same-cycle read and write never occur, because write wins.
- clken low:
  - Freezes every pipeline stage, readdata and readdatavalid (held, not re-pulsed), the FSM and the clear counter.
  - Accepts no request.
  - A valid held across a stall counts as one beat, delivered on the first enabled edge.
- Reset mid-operation: in-flight reads are discarded and readdatavalid = 0 immediately.
  - CLEAR_ON_RESET = 1: re-enters INIT and re-clears memory.
  - CLEAR_ON_RESET = 0: contents are preserved but undefined.
- Out-of-range address: not possible; the address is exactly ADDR_W bits.

Test Plan:
- Clear sequence: ADDR_W = 4, CLEAR_ON_RESET = 1; release reset.
  - Required: waitrequest = 1 for 16 cycles, then 0 with init_done = 1.
  - Reads of addresses 0..15 all return 0x00000000.
- Byte-lane write: write 0xAABBCCDD to addr 3 with byteenable = 4'b1111, then 0x11223344 to addr 3 with byteenable = 4'b0101.
  - Required: a read of addr 3 returns 0xAA22CC44.
- Latency: READ_LATENCY = 2; reads to addrs 1, 2, 3 on consecutive cycles.
  - Required: readdatavalid high on cycles t+2, t+3, t+4, with data in order.
- Read-after-write: write 0xDEADBEEF to addr 7 at cycle t, read addr 7 at t+1.
  - Required: readdata = 0xDEADBEEF when readdatavalid pulses.
- Stall: READ_LATENCY = 1; accept a read, drop clken for 3 cycles.
  - Required: waitrequest = 1 for those 3 cycles and readdatavalid stays held.
  - Exactly one valid beat is delivered after clken returns; requests during the stall are ignored.
- Reset mid-read: assert reset_n = 0 one cycle after a read is accepted.
  - Required: readdatavalid = 0 immediately, no stale beat after release, INIT restarts.
